// File: rtl/riscv_pkg.sv
// riscv_pkg: FSM state encoding shared by the data-memory controller and CPU opcode constants.
package riscv_pkg;
  typedef enum logic [1:0] {IDLE, WAITS, ACCESS, RESP} state_t;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] S_I = 7'b0100011;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: M x REG_WIDTH storage, synchronous write, registered read, no reset.
module dmem_array #(
  parameter int M         = 100,
  parameter int REG_WIDTH = 32,
  parameter int AW        = 7
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [AW-1:0]        i_addr,
  input  logic [REG_WIDTH-1:0] i_wdata,
  output logic [REG_WIDTH-1:0] o_rdata
);
  logic [REG_WIDTH-1:0] r_mem [M];
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_addr];
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: wait-stated load/store controller in front of dmem_array.
// Define DMEM_BOUNDS_CHECK_EN to fault misaligned or out-of-range accesses.
module dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int M         = 100,
  parameter int REG_WIDTH = 32,
  parameter int WAIT      = 2
) (
  input  logic                 CLOCK_50,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [31:0]          addr,
  input  logic [REG_WIDTH-1:0] wdata,
  output logic                 ready,
  output logic                 done,
  output logic [REG_WIDTH-1:0] rdata,
  output logic                 err,
  output logic [31:0]          access_count
);
  localparam int AW = M > 1 ? $clog2(M) : 1;
  localparam int CW = WAIT > 1 ? $clog2(WAIT) : 1;
  state_t               r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic                 r_we;
  logic [31:0]          r_addr;
  logic [REG_WIDTH-1:0] r_wdata, r_rdata, w_q;
  logic                 w_fault;
`ifdef DMEM_BOUNDS_CHECK_EN
  assign w_fault = (r_addr[1:0] != 2'b00) || ({2'b00, r_addr[31:2]} >= 32'(M));
`else
  logic w_unused;
  assign w_fault  = 1'b0;
  assign w_unused = ^{r_addr[1:0], r_addr[31:AW+2]};
`endif
  assign ready = r_state == IDLE;
  assign done  = r_state == RESP;
  assign err   = done & w_fault;
  assign rdata = done ? ((r_we || w_fault) ? '0 : w_q) : r_rdata;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req) w_next = (WAIT > 0) ? WAITS : ACCESS;
      WAITS:   if (r_cnt == '0) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rdata      <= '0;
      access_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req) r_cnt <= CW'(WAIT > 0 ? WAIT - 1 : 0);
      else if (r_state == WAITS && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (done) begin
        r_rdata      <= rdata;
        access_count <= access_count + 32'd1;
      end
    end
  end
  // request fields are captured once on accept and held for the whole access
  always_ff @(posedge CLOCK_50) begin
    if (ready && req) begin
      r_we    <= we;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end
  dmem_array #(.M(M), .REG_WIDTH(REG_WIDTH), .AW(AW)) u_array (
    .i_clk   (CLOCK_50),
    .i_we    (r_state == ACCESS && r_we && !w_fault),
    .i_re    (r_state == ACCESS && !r_we && !w_fault),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_q)
  );
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl with WAIT=2 (instance 0) and WAIT=0 (instance 1).
module tb_dmem_ctrl;
  typedef struct {logic [31:0] rd; logic er; int cyc;} exp_t;
  exp_t        q0[$], q1[$];
  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  req = '0, we = '0, ready, done, err;
  logic [31:0] addr[2], wdata[2], rdata[2], cnt[2];
  int          cyc = 0, pass_n = 0, tot_n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_ctrl #(.WAIT(2)) u0 (.CLOCK_50(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ready(ready[0]), .done(done[0]), .rdata(rdata[0]), .err(err[0]), .access_count(cnt[0]));
  dmem_ctrl #(.WAIT(0)) u1 (.CLOCK_50(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ready(ready[1]), .done(done[1]), .rdata(rdata[1]), .err(err[1]), .access_count(cnt[1]));

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endfunction

  function automatic void push(int s, logic [31:0] rd, logic er, int c);
    exp_t e;
    e.rd = rd; e.er = er; e.cyc = c;
    if (s == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (done[s]) begin
        exp_t e;
        if ((s == 0 ? q0.size() : q1.size()) == 0) chk($sformatf("spurious done u%0d", s), 1, 0);
        else begin
          if (s == 0) e = q0.pop_front(); else e = q1.pop_front();
          chk($sformatf("rdata u%0d", s), rdata[s], e.rd);
          chk($sformatf("err u%0d", s), {31'd0, err[s]}, {31'd0, e.er});
          chk($sformatf("done cycle u%0d", s), cyc, e.cyc);
        end
      end
    end
  end

  // issue one access at a negedge; returns at the negedge after the accepting edge
  task automatic acc(int s, logic w, logic [31:0] a, logic [31:0] d, logic [31:0] rd, logic er);
    int n = 0;
    while (!ready[s] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ready timeout", 0, 1);
    req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
    @(negedge clk);
    push(s, rd, er, cyc + (s == 0 ? 3 : 1));
    req[s] = 1'b0; we[s] = ~w; addr[s] = ~a; wdata[s] = ~d;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("drain timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int c0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    #2 rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset ready", {31'd0, ready[s]}, 32'd1);
      chk("reset done", {31'd0, done[s]}, 32'd0);
      chk("reset err", {31'd0, err[s]}, 32'd0);
      chk("reset rdata", rdata[s], 32'd0);
      chk("reset count", cnt[s], 32'd0);
    end
    #9 rst = 1'b1;
    @(negedge clk);
    acc(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    acc(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    acc(0, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
    acc(0, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
    drain();
    chk("count after 4", cnt[0], 32'd4);
    chk("rdata held", rdata[0], 32'hCAFEF00D);
    c0 = cyc;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    for (int k = 0; k < 4; k++) push(0, 32'hDEADBEEF, 1'b0, c0 + 4 + 5 * k);
    repeat (20) @(negedge clk);
    req[0] = 1'b0;
    chk("count after hold", cnt[0], 32'd8);
    drain();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678;
    @(negedge clk);
    req[0] = 1'b0;
    rst = 1'b0;
    #1;
    chk("midop ready", {31'd0, ready[0]}, 32'd1);
    chk("midop done", {31'd0, done[0]}, 32'd0);
    chk("midop count", cnt[0], 32'd0);
    chk("midop rdata", rdata[0], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    acc(0, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
    acc(0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    acc(0, 1'b0, 32'h190, 32'h0, 32'h0, 1'b1);
    acc(0, 1'b1, 32'h11, 32'h0BADBAD0, 32'h0, 1'b1);
    acc(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    drain();
    chk("count after faults", cnt[0], 32'd5);
`else
    acc(0, 1'b0, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0);
    acc(0, 1'b0, 32'h210, 32'h0, 32'hDEADBEEF, 1'b0);
    drain();
    chk("count after alias", cnt[0], 32'd3);
`endif
    acc(1, 1'b1, 32'h8, 32'h55AA55AA, 32'h0, 1'b0);
    acc(1, 1'b0, 32'h8, 32'h0, 32'h55AA55AA, 1'b0);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8; wdata[1] = 32'h0;
    @(negedge clk);
    req[1] = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("count no extra", cnt[1], 32'd2);
    acc(1, 1'b0, 32'h8, 32'h0, 32'h55AA55AA, 1'b0);
    drain();
    chk("count w0", cnt[1], 32'd3);
    chk("queue empty", q0.size() + q1.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
